// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS IF stage: reset PC, bubble instruction,
// datapath width and a small helper for word-aligning branch targets.
package fetch_stage_pkg;

    localparam int          INSTR_W       = 32;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    // Instructions are word aligned, so the two low address bits are dropped.
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pipe_reg.sv
// Generic pipeline register with a synchronous reset, a load enable and a
// flush that forces the register to a fixed bubble value.
module pipe_reg #(
    parameter int           W         = 32,
    parameter logic [W-1:0] FLUSH_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset and flush both insert the bubble, and flush beats a held stage.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= FLUSH_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, PC+4 adder, EX-stage
// redirect, IF/ID pipeline register and saturating stall/flush debug counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_pc4,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             align_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int IFID_W = 1 + 2 * INSTR_W;

    logic [31:0]       pc_plus4;
    logic [IFID_W-1:0] if_id_d;
    logic [IFID_W-1:0] if_id_q;

    // Sequential fetch; the adder wraps naturally at the top of memory.
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // A redirect from an older instruction in EX overrides a load-use stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_target);
        end else if (pc_write) begin
            pc <= pc_plus4;
        end
    end

    // Misaligned redirect targets are still taken, but flagged for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            align_err <= 1'b0;
        end else begin
            align_err <= redirect_valid & (|redirect_target[1:0]);
        end
    end

    // Debug counters: stalls only count when no flush is squashing the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!if_id_write && !redirect_valid && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
            if (redirect_valid && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    assign if_id_d = {1'b1, pc_plus4, imem_rdata};

    pipe_reg #(
        .W         (IFID_W),
        .FLUSH_VAL ({1'b0, 32'h0000_0000, NOP_INSTR})
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (if_id_write),
        .flush (redirect_valid),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign {if_id_valid, if_id_pc4, if_id_instr} = if_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations followed by random traffic compared against a behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        if_id_write;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    logic [31:0] imem_addr,  imem_rdata,  pc,  if_id_pc4,  if_id_instr;
    logic        if_id_valid,  align_err;
    logic [15:0] stall_count,  flush_count;

    logic [31:0] imem_addr_s, imem_rdata_s, pc_s, if_id_pc4_s, if_id_instr_s;
    logic        if_id_valid_s, align_err_s;
    logic [1:0]  stall_count_s, flush_count_s;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid, m_align;
    int          m_stall, m_flush;

    fetch_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
        .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .align_err(align_err), .stall_count(stall_count), .flush_count(flush_count)
    );

    fetch_stage #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr_s), .imem_rdata(imem_rdata_s), .pc(pc_s),
        .if_id_pc4(if_id_pc4_s), .if_id_instr(if_id_instr_s), .if_id_valid(if_id_valid_s),
        .align_err(align_err_s), .stall_count(stall_count_s), .flush_count(flush_count_s)
    );

    // Instruction memory: each word's content is its address xor a pattern
    assign imem_rdata   = imem_addr   ^ 32'hA5A5_0000;
    assign imem_rdata_s = imem_addr_s ^ 32'hA5A5_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model of one clock edge, written from the stage's architectural rules
    task automatic modelEdge();
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_align = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            m_align = redirect_valid && (redirect_target % 4 != 0);
            if (redirect_valid) begin
                m_pc    = redirect_target - (redirect_target % 4);
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                m_flush = m_flush + 1;
            end else begin
                if (!if_id_write) begin
                    m_stall = m_stall + 1;
                end else begin
                    m_instr = old_pc ^ 32'hA5A5_0000;
                    m_pc4   = old_pc + 32'd4;
                    m_valid = 1'b1;
                end
                if (pc_write) m_pc = old_pc + 32'd4;
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("pc",          pc,          m_pc);
        checkVal("imem_addr",   imem_addr,   m_pc);
        checkVal("if_id_pc4",   if_id_pc4,   m_pc4);
        checkVal("if_id_instr", if_id_instr, m_instr);
        checkVal("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        checkVal("align_err",   {31'b0, align_err},   {31'b0, m_align});
        checkVal("stall_count", {16'b0, stall_count}, (m_stall > 65535) ? 32'd65535 : 32'(m_stall));
        checkVal("flush_count", {16'b0, flush_count}, (m_flush > 65535) ? 32'd65535 : 32'(m_flush));
        checkVal("small_pc",    pc_s,        m_pc);
        checkVal("small_instr", if_id_instr_s, m_instr);
        checkVal("small_stall", {30'b0, stall_count_s}, (m_stall > 3) ? 32'd3 : 32'(m_stall));
        checkVal("small_flush", {30'b0, flush_count_s}, (m_flush > 3) ? 32'd3 : 32'(m_flush));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare
    task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] tgt,
                                 input logic pw, input logic ifw);
        reset = rst; redirect_valid = rv; redirect_target = tgt;
        pc_write = pw; if_id_write = ifw;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        reset = 1'b1; pc_write = 1'b1; if_id_write = 1'b1;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        m_align = 1'b0; m_stall = 0; m_flush = 0;

        // Reset state
        applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 1, 1);
        checkVal("lit_reset_pc",    pc,                   32'h0);
        checkVal("lit_reset_valid", {31'b0, if_id_valid}, 32'h0);

        // Sequential fetch from 0
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkVal("lit_seq_pc",    pc,          32'h8);
        checkVal("lit_seq_instr", if_id_instr, 32'hA5A5_0004);
        checkVal("lit_seq_pc4",   if_id_pc4,   32'h8);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);

        // Two-cycle stall at 0x10
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkVal("lit_stall_pc",    pc,                   32'h10);
        checkVal("lit_stall_instr", if_id_instr,          32'hA5A5_000C);
        checkVal("lit_stall_count", {16'b0, stall_count}, 32'd2);
        applyStimulus(0, 0, 0, 1, 1);
        checkVal("lit_resume_pc", pc, 32'h14);

        // Redirect during a load-use stall
        applyStimulus(0, 1, 32'h100, 0, 0);
        checkVal("lit_redir_pc",    pc,                   32'h100);
        checkVal("lit_redir_valid", {31'b0, if_id_valid}, 32'h0);
        checkVal("lit_redir_flush", {16'b0, flush_count}, 32'd1);
        applyStimulus(0, 0, 0, 1, 1);
        checkVal("lit_after_redir_instr", if_id_instr, 32'hA5A5_0100);

        // Misaligned target
        applyStimulus(0, 1, 32'h103, 1, 1);
        checkVal("lit_align_pc",  pc,                 32'h100);
        checkVal("lit_align_err", {31'b0, align_err}, 32'h1);
        applyStimulus(0, 0, 0, 1, 1);
        checkVal("lit_align_clear", {31'b0, align_err}, 32'h0);

        // Wrap at the top of the address space
        applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkVal("lit_wrap_pc",  pc,        32'h0);
        checkVal("lit_wrap_pc4", if_id_pc4, 32'h0);

        // Saturation of the narrow counter
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        checkVal("lit_sat_small", {30'b0, stall_count_s}, 32'd3);
        checkVal("lit_sat_big",   {16'b0, stall_count},   32'd7);

        // Reset coinciding with a redirect
        applyStimulus(1, 1, 32'h200, 0, 0);
        checkVal("lit_rr_pc",    pc,                   32'h0);
        checkVal("lit_rr_valid", {31'b0, if_id_valid}, 32'h0);
        checkVal("lit_rr_flush", {16'b0, flush_count}, 32'h0);
        applyStimulus(0, 0, 0, 1, 1);
        checkVal("lit_rr_instr", if_id_instr, 32'hA5A5_0000);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 7) == 0),
                          $urandom(),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
